// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter (mem_arbiter).
// States, owner encoding, access-size codes and the default I/O base live here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSB = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // Byte count of a load/store; the illegal code 3 behaves as a word.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way requester picker producing a one-hot grant indexed by owner_t.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise the LSB always wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_if_elig,
    input  logic       i_lsb_elig,
`ifdef MEM_ARB_RR_EN
    input  owner_t     i_last_grant,
`endif
    output logic [1:0] o_grant
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        o_grant = 2'b00;
        if (i_if_elig && i_lsb_elig) begin
`ifdef MEM_ARB_RR_EN
            if (i_last_grant == OWN_LSB) begin
                o_grant[OWN_IF] = 1'b1;
            end else begin
                o_grant[OWN_LSB] = 1'b1;
            end
`else
            o_grant[OWN_LSB] = 1'b1;
`endif
        end else if (i_if_elig) begin
            o_grant[OWN_IF] = 1'b1;
        end else if (i_lsb_elig) begin
            o_grant[OWN_LSB] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide memory port between instruction fetch and the LSB,
// sequencing byte bursts. Optional round-robin tie-break: define MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rdy,
    input  logic        i_flush,
    input  logic        i_io_buffer_full,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ready,
    output logic [31:0] o_if_data,
    input  logic        i_lsb_req,
    input  logic        i_lsb_we,
    input  logic [1:0]  i_lsb_size,
    input  logic [31:0] i_lsb_addr,
    input  logic [31:0] i_lsb_wdata,
    output logic        o_lsb_ready,
    output logic [31:0] o_lsb_rdata,
    input  logic [7:0]  i_mem_din,
    output logic [7:0]  o_mem_dout,
    output logic [31:0] o_mem_a,
    output logic        o_mem_wr
);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [2:0]  r_len, w_len_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic        r_we, w_we_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    owner_t      r_owner, w_owner_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic        r_stalled;

    logic        w_if_elig;
    logic        w_lsb_elig;
    logic [1:0]  w_grant;
    logic        w_flush_if;
    logic        w_pending;
    logic        w_reissue;
    logic [2:0]  w_issue_idx;
    logic [1:0]  w_lane;

`ifdef MEM_ARB_RR_EN
    owner_t      r_last_grant;
`endif

    assign w_if_elig  = i_if_req && !i_flush;
    assign w_lsb_elig = i_lsb_req &&
                        !(i_lsb_we && (i_lsb_addr >= IO_BASE) && i_io_buffer_full);

    mem_arb_pick u_pick (
        .i_if_elig    (w_if_elig),
        .i_lsb_elig   (w_lsb_elig),
`ifdef MEM_ARB_RR_EN
        .i_last_grant (r_last_grant),
`endif
        .o_grant      (w_grant)
    );

    assign w_flush_if = i_flush && (r_owner == OWN_IF) &&
                        ((r_state == S_READ) || (r_state == S_DONE));

    // A byte issued just before a stall has its data lost while frozen, so the
    // address is re-presented during the stall and for one resume cycle.
    assign w_pending   = (r_state == S_READ) && (r_cnt != 3'd0);
    assign w_reissue   = w_pending && (!i_rdy || r_stalled);
    assign w_issue_idx = w_reissue ? (r_cnt - 3'd1) : r_cnt;
    assign w_lane      = r_cnt[1:0] - 2'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_addr_nxt  = r_addr;
        w_we_nxt    = r_we;
        w_wdata_nxt = r_wdata;
        w_owner_nxt = r_owner;
        w_data_nxt  = r_data;
        o_mem_a     = 32'd0;
        o_mem_dout  = 8'd0;
        o_mem_wr    = 1'b0;
        o_if_ready  = 1'b0;
        o_if_data   = 32'd0;
        o_lsb_ready = 1'b0;
        o_lsb_rdata = 32'd0;

        unique case (r_state)
            S_IDLE: begin
                if (w_grant[OWN_LSB]) begin
                    w_owner_nxt = OWN_LSB;
                    w_addr_nxt  = i_lsb_addr;
                    w_len_nxt   = size_to_len(i_lsb_size);
                    w_we_nxt    = i_lsb_we;
                    w_wdata_nxt = i_lsb_wdata;
                    w_data_nxt  = 32'd0;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = i_lsb_we ? S_WRITE : S_READ;
                end else if (w_grant[OWN_IF]) begin
                    w_owner_nxt = OWN_IF;
                    w_addr_nxt  = i_if_addr;
                    w_len_nxt   = 3'd4;
                    w_we_nxt    = 1'b0;
                    w_wdata_nxt = 32'd0;
                    w_data_nxt  = 32'd0;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = S_READ;
                end
            end

            S_READ: begin
                if (w_issue_idx < r_len) begin
                    o_mem_a = r_addr + {29'd0, w_issue_idx};
                end
                if (w_flush_if) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else if (!(r_stalled && w_pending)) begin
                    if (w_pending) begin
                        w_data_nxt[{w_lane, 3'b000} +: 8] = i_mem_din;
                    end
                    if (r_cnt == r_len) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end

            S_WRITE: begin
                o_mem_a    = r_addr + {29'd0, r_cnt};
                o_mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                o_mem_wr   = i_rdy;
                if (r_cnt == r_len - 3'd1) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
                if (r_owner == OWN_IF) begin
                    if (!w_flush_if) begin
                        o_if_ready = i_rdy;
                        o_if_data  = r_data;
                    end
                end else begin
                    o_lsb_ready = i_rdy;
                    o_lsb_rdata = r_data;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_len     <= 3'd0;
            r_addr    <= 32'd0;
            r_we      <= 1'b0;
            r_wdata   <= 32'd0;
            r_owner   <= OWN_LSB;
            r_data    <= 32'd0;
            r_stalled <= 1'b0;
        end else begin
            r_stalled <= !i_rdy;
            if (i_rdy) begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_len   <= w_len_nxt;
                r_addr  <= w_addr_nxt;
                r_we    <= w_we_nxt;
                r_wdata <= w_wdata_nxt;
                r_owner <= w_owner_nxt;
                r_data  <= w_data_nxt;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= OWN_LSB;
        end else if (i_rdy && (r_state == S_IDLE) && (w_grant != 2'b00)) begin
            r_last_grant <= w_grant[OWN_IF] ? OWN_IF : OWN_LSB;
        end
    end
`endif

endmodule
